// File: rtl/rv_mc_ctrl.sv
// ---------------------------------------------------------------------------
// rv_mc_ctrl
// Multi-cycle control FSM for an RV32I core. Sequences fetch, decode,
// execute, memory and writeback. Drives the ALU operation and the operand
// and result muxes, and resolves branches from the ALU Z/N flags. Also runs
// the memory request/ready handshake.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : an unknown opcode parks the FSM in S_BADOP with illegal=1
//               until reset
//   undefined : S_BADOP is a one-cycle NOP back to fetch; illegal stays 0
//
// Parameters:
//   RESET_HOLD  cycles spent in S_RESET after rst_n releases (min 1)
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   op, funct3, funct7b5  instruction fields from the registered IR
//   alu_z, alu_n          ALU zero / negative (ltu for sltu op) flags
//   mem_ready             memory completes the current access this cycle
//   mem_req, mem_we       memory request and write strobe
//   adr_src               address mux: 0=PC, 1=ALU result register
//   ir_write, pc_write    IR/oldPC latch enable, PC update enable
//   reg_write             register file write enable
//   alu_src_a             0=PC, 1=oldPC, 2=rs1
//   alu_src_b             0=rs2, 1=imm, 2=const 4
//   result_src            0=ALU reg, 1=mem data, 2=ALU direct
//   imm_src               0=I, 1=S, 2=B, 3=J, 4=U
//   alu_control           ALU op code
//   illegal               illegal-opcode indicator
// ---------------------------------------------------------------------------
module rv_mc_ctrl #(
    parameter int RESET_HOLD = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       alu_z,
    input  logic       alu_n,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal
);

    localparam int CW = $clog2(RESET_HOLD + 1);

    typedef enum logic [3:0] {
        S_RESET, S_FETCH, S_DECODE, S_MEMADR,
        S_MEMRD, S_MEMWB, S_MEMWR, S_EXECR,
        S_EXECI, S_ALUWB, S_BRANCH, S_JAL,
        S_JALWB, S_JALR, S_LUI,   S_BADOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] hold_q, hold_d;

    // State and reset-hold counter. The async reset forces S_RESET, so every
    // output (all decoded from state) drops immediately, including mem_req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RESET;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state and output decode. Every output defaults to 0 so that each
    // state only names the controls it actually uses.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        result_src  = 2'd0;
        imm_src     = 3'd0;
        alu_control = 4'b0000;
        illegal     = 1'b0;

        case (state_q)
            S_RESET: begin
                // The first edge after release only advances the counter, so
                // a release near an edge still gets RESET_HOLD full cycles.
                if (hold_q == CW'(RESET_HOLD)) begin
                    state_d = S_FETCH;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'd2;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target oldPC + B-imm is computed speculatively here.
                alu_src_a = 2'd1;
                alu_src_b = 2'd1;
                imm_src   = 3'd2;
                case (op)
                    7'b0000011, 7'b0100011: state_d = S_MEMADR;
                    7'b0110011:             state_d = S_EXECR;
                    7'b0010011:             state_d = S_EXECI;
                    7'b1100011:             state_d = S_BRANCH;
                    7'b1101111:             state_d = S_JAL;
                    7'b1100111:             state_d = S_JALR;
                    7'b0110111:             state_d = S_LUI;
                    default:                state_d = S_BADOP;
                endcase
            end
            S_MEMADR: begin
                // op[5] separates store (0100011) from load (0000011).
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = op[5] ? 3'd1 : 3'd0;
                state_d   = op[5] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'd1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                alu_src_a = 2'd2;
                alu_src_b = (state_q == S_EXECI) ? 2'd1 : 2'd0;
                case (funct3)
                    3'b000: alu_control = (state_q == S_EXECR && funct7b5) ? 4'b0001 : 4'b0000;
                    3'b001: alu_control = 4'b0111;
                    3'b010: alu_control = 4'b0101;
                    3'b011: alu_control = 4'b1010;
                    3'b100: alu_control = 4'b0110;
                    3'b101: alu_control = funct7b5 ? 4'b1001 : 4'b1000;
                    3'b110: alu_control = 4'b0011;
                    default: alu_control = 4'b0010;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                // Unsigned compares use sltu so that N carries ltu; the signed
                // and equality compares use a plain subtract.
                alu_src_a   = 2'd2;
                alu_control = (funct3[2:1] == 2'b11) ? 4'b1010 : 4'b0001;
                case (funct3)
                    3'b000:  pc_write = alu_z;
                    3'b001:  pc_write = ~alu_z;
                    3'b100,
                    3'b110:  pc_write = alu_n;
                    3'b101,
                    3'b111:  pc_write = ~alu_n;
                    default: pc_write = 1'b0;
                endcase
                state_d = S_FETCH;
            end
            S_JAL: begin
                pc_write = 1'b1;
                state_d  = S_JALWB;
            end
            S_JALWB: begin
                // Link value is oldPC + 4.
                alu_src_a  = 2'd1;
                alu_src_b  = 2'd2;
                result_src = 2'd2;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'd2;
                alu_src_b  = 2'd1;
                result_src = 2'd2;
                pc_write   = 1'b1;
                state_d    = S_JALWB;
            end
            S_LUI: begin
                // Datapath forces rs1 to x0 for LUI, so this is 0 + U-imm.
                alu_src_a = 2'd2;
                alu_src_b = 2'd1;
                imm_src   = 3'd4;
                state_d   = S_ALUWB;
            end
            S_BADOP: begin
`ifdef ILLEGAL_TRAP_EN
                illegal = 1'b1;
                state_d = S_BADOP;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rv_mc_ctrl
// Directed bench for rv_mc_ctrl. The driver issues one input vector per
// cycle and queues the hand-computed output word for that cycle; a monitor
// on the falling edge pops each entry and compares it with the DUT outputs.
// Output word: {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
//               alu_src_a, alu_src_b, result_src, imm_src, alu_control,
//               illegal}
// ---------------------------------------------------------------------------
module tb_rv_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       alu_z;
    logic       alu_n;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal;

    typedef struct {
        string       name;
        logic [19:0] exp;
    } expEntry_t;

    expEntry_t   expQ[$];
    int          vectors     = 0;
    int          miscompares = 0;
    logic [19:0] actVec;
    logic [19:0] vIdle, vFetchWait, vFetchGo, vDecode, vAluWb, vJalWb;

    rv_mc_ctrl #(.RESET_HOLD(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .alu_z      (alu_z),
        .alu_n      (alu_n),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alu_control(alu_control),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign actVec = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                     alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal};

    function automatic logic [19:0] ov(input logic req, input logic we, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic [2:0] imm,
                                       input logic [3:0] ac, input logic ill);
        return {req, we, adr, irw, pcw, rw, sa, sb, rs, imm, ac, ill};
    endfunction

    // Compare one queued expectation against the live outputs.
    task automatic checkOutput(input string name, input logic [19:0] exp);
        vectors++;
        if (actVec !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, actVec, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected in that cycle.
    task automatic applyStimulus(input string name, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7,
                                 input logic z, input logic n, input logic rdy,
                                 input logic [19:0] exp);
        expEntry_t e;
        op        = o;
        funct3    = f3;
        funct7b5  = f7;
        alu_z     = z;
        alu_n     = n;
        mem_ready = rdy;
        e.name    = name;
        e.exp     = exp;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetchDecode(input string nm, input logic [6:0] o,
                               input logic [2:0] f3, input logic f7);
        applyStimulus({nm, "_fetch"},  o, f3, f7, 1'b0, 1'b0, 1'b1, vFetchGo);
        applyStimulus({nm, "_decode"}, o, f3, f7, 1'b0, 1'b0, 1'b0, vDecode);
    endtask

    task automatic aluOp(input string nm, input logic [6:0] o, input logic [2:0] f3,
                         input logic f7, input logic [3:0] ac);
        fetchDecode(nm, o, f3, f7);
        applyStimulus({nm, "_exec"}, o, f3, f7, 1'b0, 1'b0, 1'b0,
                      ov(0, 0, 0, 0, 0, 0, 2'd2, (o == 7'b0010011) ? 2'd1 : 2'd0,
                         2'd0, 3'd0, ac, 0));
        applyStimulus({nm, "_wb"}, o, f3, f7, 1'b0, 1'b0, 1'b0, vAluWb);
    endtask

    task automatic branchOp(input string nm, input logic [2:0] f3, input logic z,
                            input logic n, input logic [3:0] ac, input logic taken);
        fetchDecode(nm, 7'b1100011, f3, 1'b0);
        applyStimulus({nm, "_branch"}, 7'b1100011, f3, 1'b0, z, n, 1'b0,
                      ov(0, 0, 0, 0, taken, 0, 2'd2, 2'd0, 2'd0, 3'd0, ac, 0));
    endtask

    task automatic releaseReset(input string nm);
        rst_n = 1'b1;
        applyStimulus({nm, "_hold0"}, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, vIdle);
        applyStimulus({nm, "_hold1"}, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, vIdle);
    endtask

    // Monitor: pops one expectation per cycle on the falling edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            expEntry_t e;
            e = expQ.pop_front();
            checkOutput(e.name, e.exp);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vIdle      = ov(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0);
        vFetchWait = ov(1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0);
        vFetchGo   = ov(1, 0, 0, 1, 1, 0, 2'd0, 2'd2, 2'd0, 3'd0, 4'd0, 0);
        vDecode    = ov(0, 0, 0, 0, 0, 0, 2'd1, 2'd1, 2'd0, 3'd2, 4'd0, 0);
        vAluWb     = ov(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0);
        vJalWb     = ov(0, 0, 0, 0, 0, 1, 2'd1, 2'd2, 2'd2, 3'd0, 4'd0, 0);

        rst_n = 1'b0;
        op = '0; funct3 = '0; funct7b5 = 1'b0;
        alu_z = 1'b0; alu_n = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus("in_reset", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, vIdle);

        // Release: two idle cycles, then fetch requests memory.
        releaseReset("release");
        for (int i = 0; i < 3; i++)
            applyStimulus("fetch_stall", 7'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, vFetchWait);

        aluOp("add",   7'b0110011, 3'b000, 1'b0, 4'b0000);
        aluOp("sub",   7'b0110011, 3'b000, 1'b1, 4'b0001);
        aluOp("srai",  7'b0010011, 3'b101, 1'b1, 4'b1001);
        aluOp("sltiu", 7'b0010011, 3'b011, 1'b0, 4'b1010);
        aluOp("or",    7'b0110011, 3'b110, 1'b0, 4'b0011);
        aluOp("addi7", 7'b0010011, 3'b000, 1'b1, 4'b0000);

        branchOp("beq_t",  3'b000, 1'b1, 1'b0, 4'b0001, 1'b1);
        branchOp("bltu_n", 3'b110, 1'b0, 1'b0, 4'b1010, 1'b0);
        branchOp("bge_n",  3'b101, 1'b0, 1'b1, 4'b0001, 1'b0);
        branchOp("bne_t",  3'b001, 1'b0, 1'b0, 4'b0001, 1'b1);

        // Load with memory ready delayed two cycles.
        fetchDecode("lw", 7'b0000011, 3'b010, 1'b0);
        applyStimulus("lw_memadr", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0, 0));
        applyStimulus("lw_rd0", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
        applyStimulus("lw_rd1", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
        applyStimulus("lw_rd2", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1,
                      ov(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
        applyStimulus("lw_wb", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 3'd0, 4'd0, 0));

        fetchDecode("sw", 7'b0100011, 3'b010, 1'b0);
        applyStimulus("sw_memadr", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd1, 4'd0, 0));
        applyStimulus("sw_wr", 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1,
                      ov(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));

        fetchDecode("jal", 7'b1101111, 3'b000, 1'b0);
        applyStimulus("jal_pc", 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
        applyStimulus("jal_wb", 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, vJalWb);

        fetchDecode("jalr", 7'b1100111, 3'b000, 1'b0);
        applyStimulus("jalr_pc", 7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(0, 0, 0, 0, 1, 0, 2'd2, 2'd1, 2'd2, 3'd0, 4'd0, 0));
        applyStimulus("jalr_wb", 7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, vJalWb);

        fetchDecode("lui", 7'b0110111, 3'b000, 1'b0);
        applyStimulus("lui_exec", 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd4, 4'd0, 0));
        applyStimulus("lui_wb", 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, vAluWb);

        // Reset in the middle of a load: request drops at once, no writeback.
        fetchDecode("lwrst", 7'b0000011, 3'b010, 1'b0);
        applyStimulus("lwrst_memadr", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(0, 0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd0, 3'd0, 4'd0, 0));
        applyStimulus("lwrst_rd", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0,
                      ov(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 0));
        rst_n = 1'b0;
        applyStimulus("midrst_drop", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, vIdle);
        applyStimulus("midrst_nowb", 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, vIdle);
        releaseReset("rerelease");

        // Illegal opcode.
        fetchDecode("badop", 7'b0000000, 3'b000, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++)
            applyStimulus("badop_trap", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1,
                          ov(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 4'd0, 1));
`else
        applyStimulus("badop_nop", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, vIdle);
        applyStimulus("badop_refetch", 7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, vFetchWait);
`endif

        @(posedge clk);
        #1;
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL queue_drain: got %0d pending expected 0", expQ.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv_mc_ctrl.md
Name: rv_mc_ctrl

Overview:
Multi-cycle control FSM for the RISC-V core. It is the initiator side of the ALU interface: it drives alu_control and the operand and result muxes, then consumes the ALU's Z/N flags to resolve branches. It sequences fetch, decode, execute, memory and writeback for RV32I. It also handles the memory request/ready handshake.

Parameters:
RESET_HOLD, 1, cycles spent in S_RESET after rst_n deasserts before the first fetch (min 1).

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  instr[6:0], valid from S_DECODE onward (IR registered)
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
alu_z  input  1  ALU zero flag (result == 0)
alu_n  input  1  ALU negative flag; equals ltu when alu_control=1010
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request, held until mem_ready
mem_we  output  1  write strobe, valid with mem_req
adr_src  output  1  0=PC, 1=ALU result register
ir_write  output  1  latch instruction/oldPC
pc_write  output  1  update PC this cycle
reg_write  output  1  register file write enable
alu_src_a  output  2  0=PC, 1=oldPC, 2=rs1
alu_src_b  output  2  0=rs2, 1=imm, 2=const 4
result_src  output  2  0=ALU reg, 1=mem data, 2=ALU direct
imm_src  output  3  0=I,1=S,2=B,3=J,4=U
alu_control  output  4  ALU op code
illegal  output  1  illegal-opcode indicator

Behaviour:
- rst_n low: state=S_RESET immediately; all outputs 0. Stay RESET_HOLD cycles after release, then go to S_FETCH.
- S_FETCH: mem_req=1, adr_src=0. Stall while mem_ready=0. On mem_ready: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=2, alu_control=0000 (PC+4), then go to S_DECODE.
- S_DECODE: alu_src_a=1, alu_src_b=1, imm_src=2, add (branch target into ALU reg). Next state by op:
  - 0000011/0100011 -> S_MEMADR
  - 0110011 -> S_EXECR
  - 0010011 -> S_EXECI
  - 1100011 -> S_BRANCH
  - 1101111 -> S_JAL
  - 1100111 -> S_JALR
  - 0110111 -> S_LUI
  - else -> S_BADOP
- S_MEMADR: rs1+imm (imm_src I for load, S for store). Next is S_MEMRD for a load, S_MEMWR for a store.
- S_MEMRD: mem_req=1, adr_src=1. Hold until mem_ready, then go to S_MEMWB.
- S_MEMWB: reg_write=1, result_src=1, then go to S_FETCH.
- S_MEMWR: mem_req=1, mem_we=1, adr_src=1. Hold until mem_ready, then go to S_FETCH.
- S_EXECR / S_EXECI: alu_src_a=2, alu_src_b=0 (R) or 1 (I), then go to S_ALUWB. alu_control decode by funct3:
  - 000: add, or sub when R and funct7b5=1
  - 001: sll 0111
  - 010: slt 0101
  - 011: sltu 1010
  - 100: xor 0110
  - 101: srl 1000, or sra 1001 when funct7b5=1 (I and R alike)
  - 110: or 0011
  - 111: and 0010
- S_ALUWB: reg_write=1, result_src=0, then go to S_FETCH.
- S_BRANCH: alu_src_a=2, alu_src_b=0, result_src=0. alu_control=0001 for funct3 0xx, 1010 for 11x. pc_write is combinational on the flags in the same cycle:
  - beq: Z
  - bne: !Z
  - blt: N
  - bge: !N
  - bltu: N
  - bgeu: !N
  - funct3 010/011: never taken
  Then go to S_FETCH.
- S_JAL: pc_write=1 (target from ALU reg), then S_JALWB with alu_src_a=1, alu_src_b=2, add, result_src=2, reg_write=1, then go to S_FETCH.
- S_JALR: alu_src_a=2, alu_src_b=1, imm I, add, result_src=2, pc_write=1, then go to S_JALWB.
- S_LUI: imm_src=4, alu_src_b=1, alu_src_a=2 with rs1 forced x0 by datapath, then go to S_ALUWB.
- Unused outputs are 0 in each state. mem_req never drops while waiting.
- Reset asserted mid-access: mem_req drops asynchronously. No writeback completes.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: S_BADOP asserts illegal=1 and stays there, with all other outputs 0, until reset.
- Undefined: S_BADOP is a one-cycle NOP that returns to S_FETCH. illegal is tied 0.

Test Plan:
- Reset release with RESET_HOLD=1 -> first mem_req=1 exactly 2 cycles after rst_n rises. Hold mem_ready=0 for 3 cycles -> mem_req stays 1 and pc_write stays 0.
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0) -> states FETCH,DECODE,EXECR,ALUWB. alu_control=0000 in EXECR, reg_write=1 only in ALUWB.
- sub and srai (f7b5=1) -> alu_control=0001 and 1001 respectively. sltiu -> 1010.
- beq with alu_z=1 -> pc_write=1 in BRANCH. bltu with alu_control=1010 and alu_n=0 -> pc_write=0. bge with alu_n=1 -> pc_write=0.
- lw with mem_ready delayed 2 cycles in MEMRD -> mem_req high for 3 cycles with adr_src=1, then reg_write=1 with result_src=1.
- op=0000000 -> with ILLEGAL_TRAP_EN defined, illegal=1 and no further mem_req. Without it, the next cycle returns to FETCH.
